// File: rtl/axis_packet_arbiter_if.sv
// axi_stream_if: AXI-Stream channel carrying tvalid/tdata/tlast forward and tready back.
interface axi_stream_if #(
    parameter int W = 32
);
    logic         tvalid;
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tready;
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: round-robin arbiter packing requester bytes into fixed-length AXI-Stream packets.
module axis_packet_arbiter #(
    parameter int N_REQ   = 4,
    parameter int PKT_LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0][7:0]    req_data,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    axi_stream_if.master             axis,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [15:0]              pkt_count
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    typedef enum logic {ARB, XFER} state_t;
    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, pick;
    logic [CW-1:0]   beat_cnt;
    logic            found, hs, last;
    int              idx;
    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end
    always_comb begin
        req_ready = '0;
        if (state == XFER) req_ready[grant_id] = !axis.tvalid || axis.tready;
    end
    assign last    = beat_cnt == CW'(PKT_LEN - 1);
    assign hs      = req_valid[grant_id] && req_ready[grant_id];
    assign busy    = state == XFER || axis.tvalid;
    assign state_n = state == ARB ? (found ? XFER : ARB) : (hs && last ? ARB : XFER);
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB;
            rr_ptr      <= '0;
            grant_id    <= '0;
            beat_cnt    <= '0;
            axis.tvalid <= 1'b0;
            axis.tdata  <= '0;
            axis.tlast  <= 1'b0;
            pkt_count   <= '0;
        end else begin
            state <= state_n;
            if (state == ARB && found) begin
                grant_id <= pick;
                rr_ptr   <= pick == IW'(N_REQ - 1) ? '0 : pick + 1'b1;
                beat_cnt <= '0;
            end
            // a new beat may load in the same cycle the previous one drains
            if (hs) begin
                axis.tdata  <= {24'h0, req_data[grant_id]};
                axis.tvalid <= 1'b1;
                axis.tlast  <= last;
                beat_cnt    <= beat_cnt + 1'b1;
            end else if (axis.tready) begin
                axis.tvalid <= 1'b0;
            end
            if (axis.tvalid && axis.tready && axis.tlast) pkt_count <= pkt_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: table-driven directed checks of the packet arbiter with N_REQ=4, PKT_LEN=4.
module tb_axis_packet_arbiter;
    localparam int N = 4;
    localparam int L = 4;
    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]    req_valid, req_ready;
    logic [1:0]      grant_id;
    logic            busy, tready;
    logic [15:0]     pkt_count;
    logic [7:0]      cnt [N];
    logic [7:0]      e [N];
    logic [N-1:0]    rr_pre;
    int              n_cmp = 0;
    int              n_bad = 0;
    axi_stream_if #(.W(32)) axis ();
    assign axis.tready = tready;
    for (genvar g = 0; g < N; g++) begin : g_src
        assign req_data[g] = cnt[g];
    end
    always #5 clk = ~clk;
    axis_packet_arbiter #(.N_REQ(N), .PKT_LEN(L)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .axis(axis), .grant_id(grant_id), .busy(busy),
        .pkt_count(pkt_count)
    );
    typedef struct {
        logic r; logic [3:0] v; logic t;
        logic [3:0] rr; logic tv; logic [31:0] td; logic tl; logic [1:0] g; logic b; logic [15:0] pc;
    } vec_t;
    vec_t tbl [$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // sources advance their byte by 0x11 on every accepted handshake
    task automatic cyc(input logic r, input logic [N-1:0] v, input logic t);
        reset = r; req_valid = v; tready = t;
        #1 rr_pre = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (v[i] && rr_pre[i]) cnt[i] = cnt[i] + 8'h11;
    endtask
    task automatic add(input logic r, input logic [3:0] v, input logic t, input logic [3:0] rr,
                       input logic tv, input logic [7:0] td, input logic tl, input logic [1:0] g,
                       input logic b, input logic [15:0] pc);
        tbl.push_back('{r, v, t, rr, tv, {24'h0, td}, tl, g, b, pc});
    endtask
    initial begin
        cnt[0] = 8'hA0; cnt[1] = 8'hB0; cnt[2] = 8'h11; cnt[3] = 8'hD0;
        // single requester 2
        add(0, 4'b0100, 1, 4'b0000, 0, 8'h00, 0, 2, 1, 0);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h11, 0, 2, 1, 0);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h22, 0, 2, 1, 0);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h33, 0, 2, 1, 0);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h44, 1, 2, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'h44, 1, 2, 0, 1);
        // backpressure on beat 2
        add(0, 4'b0100, 1, 4'b0000, 0, 8'h44, 1, 2, 1, 1);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h55, 0, 2, 1, 1);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h66, 0, 2, 1, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b0100, 0, 4'b0000, 1, 8'h66, 0, 2, 1, 1);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h77, 0, 2, 1, 1);
        add(0, 4'b0100, 1, 4'b0100, 1, 8'h88, 1, 2, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'h88, 1, 2, 0, 2);
        // requester 1 stalls while requester 3 waits
        add(0, 4'b0010, 1, 4'b0000, 0, 8'h88, 1, 1, 1, 2);
        add(0, 4'b1010, 1, 4'b0010, 1, 8'hB0, 0, 1, 1, 2);
        for (int i = 0; i < 3; i++) add(0, 4'b1000, 1, 4'b0010, 0, 8'hB0, 0, 1, 1, 2);
        add(0, 4'b1010, 1, 4'b0010, 1, 8'hC1, 0, 1, 1, 2);
        add(0, 4'b1010, 1, 4'b0010, 1, 8'hD2, 0, 1, 1, 2);
        add(0, 4'b1010, 1, 4'b0010, 1, 8'hE3, 1, 1, 1, 2);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'hE3, 1, 1, 0, 3);
        // reset after beat 2, then requesters 0 and 2 compete
        add(0, 4'b0101, 1, 4'b0000, 0, 8'hE3, 1, 2, 1, 3);
        add(0, 4'b0101, 1, 4'b0100, 1, 8'h99, 0, 2, 1, 3);
        add(0, 4'b0101, 1, 4'b0100, 1, 8'hAA, 0, 2, 1, 3);
        add(1, 4'b0101, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
        add(0, 4'b0101, 1, 4'b0000, 0, 8'h00, 0, 0, 1, 0);
        add(0, 4'b0000, 1, 4'b0001, 0, 8'h00, 0, 0, 1, 0);

        cyc(1, '0, 1);
        cyc(1, '0, 1);
        chk("reset_rr", 32'(rr_pre), 32'(4'b0000));
        chk("reset_tvalid", 32'(axis.tvalid), 0);
        chk("reset_tdata", axis.tdata, 0);
        chk("reset_tlast", 32'(axis.tlast), 0);
        chk("reset_grant", 32'(grant_id), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_pkt_count", 32'(pkt_count), 0);

        foreach (tbl[n]) begin
            cyc(tbl[n].r, tbl[n].v, tbl[n].t);
            chk($sformatf("v%0d_req_ready", n), 32'(rr_pre), 32'(tbl[n].rr));
            chk($sformatf("v%0d_tvalid", n), 32'(axis.tvalid), 32'(tbl[n].tv));
            chk($sformatf("v%0d_tdata", n), axis.tdata, tbl[n].td);
            chk($sformatf("v%0d_tlast", n), 32'(axis.tlast), 32'(tbl[n].tl));
            chk($sformatf("v%0d_grant", n), 32'(grant_id), 32'(tbl[n].g));
            chk($sformatf("v%0d_busy", n), 32'(busy), 32'(tbl[n].b));
            chk($sformatf("v%0d_pkt_count", n), 32'(pkt_count), 32'(tbl[n].pc));
        end

        // fairness: all four requesting for 8 packets
        cyc(1, '0, 1);
        for (int i = 0; i < N; i++) e[i] = cnt[i];
        for (int p = 0; p < 8; p++) begin
            cyc(0, '1, 1);
            chk($sformatf("fair%0d_arb_rr", p), 32'(rr_pre), 0);
            chk($sformatf("fair%0d_grant", p), 32'(grant_id), 32'(p % N));
            chk($sformatf("fair%0d_gap_tvalid", p), 32'(axis.tvalid), 0);
            chk($sformatf("fair%0d_pkt_count", p), 32'(pkt_count), 32'(p));
            for (int b = 0; b < L; b++) begin
                cyc(0, '1, 1);
                chk($sformatf("fair%0d_b%0d_rr", p, b), 32'(rr_pre), 32'(4'b0001 << (p % N)));
                chk($sformatf("fair%0d_b%0d_tdata", p, b), axis.tdata, {24'h0, e[p % N]});
                chk($sformatf("fair%0d_b%0d_tlast", p, b), 32'(axis.tlast), 32'(b == L - 1));
                chk($sformatf("fair%0d_b%0d_tvalid", p, b), 32'(axis.tvalid), 1);
                e[p % N] = e[p % N] + 8'h11;
            end
        end
        cyc(0, '0, 1);
        chk("fair_final_pkt_count", 32'(pkt_count), 8);
        chk("fair_final_busy", 32'(busy), 0);

        // count wrap from 0xFFFF
        force dut.pkt_count = 16'hFFFF;
        cyc(0, '0, 1);
        release dut.pkt_count;
        for (int b = 0; b <= L; b++) cyc(0, 4'b0001, 1);
        cyc(0, '0, 1);
        chk("wrap_grant", 32'(grant_id), 0);
        chk("wrap_pkt_count", 32'(pkt_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin arbiter that shares the single AXI-Stream master channel between `N_REQ` byte producers. Grants one requester at a time for a fixed-length packet of `PKT_LEN` beats, zero-extends each byte into the 32-bit `tdata`, and asserts `tlast` on the final beat. Sits between the peripheral byte sources and the streaming datapath; it replaces direct per-source drive of the stream channel.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2 to 8.
- `PKT_LEN`, 4: beats per packet; must be at least 1.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_data`  in  `N_REQ`x8: byte from each requester.
- `req_valid`  in  `N_REQ`: requester i has a byte available.
- `req_ready`  out  `N_REQ`: byte of requester i is accepted this cycle (handshake on `req_valid[i] && req_ready[i]`).
- `axis`  `axi_stream_if.master`  32-bit: drives `tvalid`, `tdata`, `tlast`; samples `tready`.
- `grant_id`  out  `$clog2(N_REQ)`: index of the current or most recent granted requester.
- `busy`  out  1: high when the state is XFER or `axis.tvalid` is high.
- `pkt_count`  out  16: count of completed packets, i.e. `tlast` handshakes on `axis`. Wraps from 0xFFFF to 0.

## Operation
- There are two states, ARB and XFER. Reset enters ARB.
- Reset values: `axis.tvalid`=0, `axis.tdata`=0, `axis.tlast`=0, `req_ready`=0, `grant_id`=0, `busy`=0, `pkt_count`=0. The round-robin pointer `rr_ptr` resets to 0, and the beat counter resets to 0.
- **ARB**
  - The arbiter scans requesters `rr_ptr`, `rr_ptr+1`, … (mod `N_REQ`) and picks the first one with `req_valid` high.
  - If one is found: `grant_id` takes that index, `rr_ptr` becomes index+1 (mod `N_REQ`), the beat counter clears to 0, and the state goes to XFER on the next edge.
  - If no requester is valid: the state stays in ARB and `rr_ptr` is unchanged.
  - `req_ready` is all zeros while in ARB.
- **XFER**
  - `req_ready[grant_id] = (!axis.tvalid || axis.tready)`. All other `req_ready` bits are 0. The expression is combinational from the registers and `axis.tready`.
  - On a requester handshake, the output register loads:
    - `tdata = {24'h0, byte}`
    - `tvalid = 1`
    - `tlast = (beat_cnt == PKT_LEN-1)`
  - The beat counter increments on each requester handshake.
  - The handshake of the last beat (`beat_cnt == PKT_LEN-1`) moves the state to ARB on the next edge.
  - If the granted requester drops `req_valid` mid-packet, the grant is held indefinitely. There is no timeout, and no other requester is served.
- **Output register**
  - When `axis.tvalid && axis.tready` and no new requester handshake occurs, `tvalid` clears to 0.
  - While `tvalid && !tready`, `tdata` and `tlast` are held stable. This is the AXI-Stream rule.
  - `tdata` and `tlast` keep their last value when `tvalid` is 0.
- `pkt_count` increments on `axis.tvalid && axis.tready && axis.tlast`.
- **Edge cases**
  - `PKT_LEN`=1: every beat carries `tlast`, and the grant rotates after every beat.
  - A requester whose `req_valid` is low during ARB is skipped for that round.
- **Reset mid-packet:** all state clears on the next edge. The in-flight beat is dropped, no `tlast` is emitted, and the next grant starts from requester 0.

## Timing
- Latency from requester handshake to `axis.tvalid` is 1 cycle (registered).
- There is a 1-cycle ARB gap after each packet's last requester handshake. With continuous `tready`, a stream of `PKT_LEN`-beat packets therefore occupies `PKT_LEN`+1 cycles per packet.
- Within a packet with `tready` high, the block sustains 1 beat per cycle, because `req_ready` is asserted whenever the output register is empty or draining.
- `grant_id` changes only on the ARB→XFER edge. It is stable for the whole packet, including while the last beat waits on `tready`.
- Worst-case wait for a continuously requesting source is `(N_REQ-1)` packets.

## Test plan
All scenarios use `N_REQ`=4 and `PKT_LEN`=4.
- **Single requester:** hold `req_valid[2]`=1 with bytes 0x11, 0x22, 0x33, 0x44 and `tready`=1.
  - Required: `tdata` = 0x00000011 … 0x00000044 on 4 consecutive cycles, `tlast` only on 0x44, `grant_id`=2, `pkt_count`=1.
- **Fairness:** hold all four `req_valid` high for 8 packets.
  - Required: `grant_id` sequence 0, 1, 2, 3, 0, 1, 2, 3, one ARB cycle between packets, `pkt_count`=8.
- **Backpressure:** hold `tready`=0 for 5 cycles on beat 2.
  - Required: `tdata` and `tlast` stable, `req_ready` low, no beat lost or duplicated, resumes at 1 beat per cycle once `tready`=1.
- **Requester stall:** granted requester 1 drops `req_valid` for 3 cycles after beat 1 while requester 3 is valid.
  - Required: grant stays 1, requester 3 gets `req_ready`=0, packet completes with exactly 4 beats.
- **Reset mid-packet:** assert `reset` for 1 cycle after beat 2.
  - Required: next cycle `tvalid`=0, `pkt_count`=0, `busy`=0, and with requesters 0 and 2 valid the next grant is 0.
- **Count wrap:** preload 65535 completed packets (or force the counter), then complete one more packet.
  - Required: `pkt_count` reads 0.
